ascon_perm_ctrl: RTL and testbench

Parametrised control FSM for the masked Ascon permutation datapath. Generalises the fixed 12-round controller in three ways:
- runtime-selectable round count (p^a = 12, p^b = 6/8, or any 1..MAX_ROUNDS);
- configurable pipeline latency per round for any masking order d;
- a valid/ready output handshake that holds the result until it is consumed.

It drives load/constant/round-enable selects and the round-constant index into the shared datapath. It never touches shares itself.

---
 rtl/ascon_perm_ctrl_if.sv | 21 ++
 rtl/ascon_perm_ctrl.sv | 141 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_ctrl_if.sv
// Request/result handshake bundle for the Ascon permutation controller.
// The master drives requests and consumes results; the controller is the slave.
interface ascon_perm_ctrl_if;
  logic       start;
  logic [3:0] nrounds;
  logic       in_ready;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic       done;

  modport master (
    output start, nrounds, out_ready,
    input  in_ready, err, out_valid, done
  );

  modport slave (
    input  start, nrounds, out_ready,
    output in_ready, err, out_valid, done
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the masked Ascon permutation datapath.
// Optional ASCON_PERM_CTRL_ABORT_EN adds an abort input.
module ascon_perm_ctrl #(
  parameter int d          = 2,
  parameter int ROUND_LAT  = 6,
  parameter int MAX_ROUNDS = 12
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ASCON_PERM_CTRL_ABORT_EN
  input  logic             abort,
`endif
  ascon_perm_ctrl_if.slave io,
  output logic             sel_load,
  output logic             sel_cst,
  output logic             round_en,
  output logic [3:0]       rc_idx,
  output logic             rnd_en,
  output logic             busy
);

  localparam int CW =
    (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam int RW =
    (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam logic [CW-1:0] CYC_LAST =
    CW'(ROUND_LAT - 1);
  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);

  if (d < 1 || ROUND_LAT < 1 || ROUND_LAT > 15 ||
      MAX_ROUNDS < 1 || MAX_ROUNDS > 15)
  begin : g_param_chk
    $error("ascon_perm_ctrl: illegal parameter");
  end

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [RW-1:0] round_cnt_q, round_cnt_d;
  logic [3:0]    nr_q, nr_d;
  logic [3:0]    rnd4;
  logic          legal;
  logic          kill;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      round_cnt_q <= '0;
      nr_q        <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      round_cnt_q <= round_cnt_d;
      nr_q        <= nr_d;
    end
  end

  always_comb begin
    kill = 1'b0;
`ifdef ASCON_PERM_CTRL_ABORT_EN
    kill = abort;
`endif
    rnd4  = 4'(round_cnt_q);
    legal = (io.nrounds != 4'd0) &&
            (io.nrounds <= MAXR);
    // cannot wrap: nr_q <= MAX_ROUNDS always
    rc_idx = MAXR - nr_q + rnd4;

    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    round_cnt_d  = round_cnt_q;
    nr_d         = nr_q;
    io.in_ready  = 1'b0;
    io.err       = 1'b0;
    io.out_valid = 1'b0;
    io.done      = 1'b0;
    sel_load     = 1'b0;
    sel_cst      = 1'b0;
    round_en     = 1'b0;
    rnd_en       = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.start && legal) begin
          sel_load    = 1'b1;
          nr_d        = io.nrounds;
          cycle_cnt_d = '0;
          round_cnt_d = '0;
          state_d     = COMPUTE;
        end else if (io.start) begin
          io.err = 1'b1;
        end
      end
      COMPUTE: begin
        rnd_en  = 1'b1;
        busy    = 1'b1;
        sel_cst = (cycle_cnt_q == '0);
        if (kill) begin
          cycle_cnt_d = '0;
          round_cnt_d = '0;
          state_d     = IDLE;
        end else if (cycle_cnt_q == CYC_LAST) begin
          round_en    = 1'b1;
          cycle_cnt_d = '0;
          if (rnd4 == nr_q - 4'd1) begin
            round_cnt_d = '0;
            state_d     = HOLD;
          end else begin
            round_cnt_d = round_cnt_q + 1'b1;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (kill) begin
          cycle_cnt_d = '0;
          round_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          io.out_valid = 1'b1;
          if (io.out_ready) begin
            io.done = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: vector table plus corner sequences.
// Instance a uses ROUND_LAT=6, instance b uses ROUND_LAT=1.
module tb_ascon_perm_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ascon_perm_ctrl_if a_if ();
  ascon_perm_ctrl_if b_if ();

  logic       a_load, a_cst, a_ren, a_rnd, a_busy;
  logic [3:0] a_rc;
  logic       b_load, b_cst, b_ren, b_rnd, b_busy;
  logic [3:0] b_rc;
`ifdef ASCON_PERM_CTRL_ABORT_EN
  logic       a_abort = 1'b0;
  logic       b_abort = 1'b0;
`endif

  ascon_perm_ctrl #(
    .d(2), .ROUND_LAT(6), .MAX_ROUNDS(12)
  ) u_a (
    .clk      (clk),
    .reset    (reset),
`ifdef ASCON_PERM_CTRL_ABORT_EN
    .abort    (a_abort),
`endif
    .io       (a_if),
    .sel_load (a_load),
    .sel_cst  (a_cst),
    .round_en (a_ren),
    .rc_idx   (a_rc),
    .rnd_en   (a_rnd),
    .busy     (a_busy)
  );

  ascon_perm_ctrl #(
    .d(2), .ROUND_LAT(1), .MAX_ROUNDS(12)
  ) u_b (
    .clk      (clk),
    .reset    (reset),
`ifdef ASCON_PERM_CTRL_ABORT_EN
    .abort    (b_abort),
`endif
    .io       (b_if),
    .sel_load (b_load),
    .sel_cst  (b_cst),
    .round_en (b_ren),
    .rc_idx   (b_rc),
    .rnd_en   (b_rnd),
    .busy     (b_busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] nr;
    int         stall;
    int         exp_err;
    int         exp_rc0;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_ren, n_cst, n_done;
    int first_v, done_t, bad, rdy_after;
    n_ren = 0; n_cst = 0; n_done = 0;
    first_v = -1; done_t = -1; bad = 0;
    rdy_after = 0;
    @(posedge clk); #1;
    a_if.start     = 1'b1;
    a_if.nrounds   = v.nr;
    a_if.out_ready = (v.stall == 0);
    #1;
    chk($sformatf("v%0d_err", idx), a_if.err, v.exp_err);
    chk($sformatf("v%0d_sel_load", idx), a_load,
        (v.exp_err == 0) ? 1 : 0);
    if (v.exp_err != 0) begin
      @(posedge clk); #1;
      a_if.start = 1'b0;
      #1;
      chk($sformatf("v%0d_idle_after_err", idx),
          {a_if.in_ready, a_busy}, 2);
      return;
    end
    for (int t = 1; t <= v.exp_lat + v.stall + 2; t++) begin
      @(posedge clk); #1;
      a_if.start     = 1'b0;
      a_if.out_ready = (t >= v.exp_lat + v.stall);
      #1;
      if (a_cst) begin
        if (t != 1 + n_cst * 6) bad++;
        n_cst++;
      end
      if (a_ren) begin
        if (t != (n_ren + 1) * 6) bad++;
        if (a_rc != v.exp_rc0 + n_ren) bad++;
        n_ren++;
      end
      if (first_v >= 0 && done_t < 0 && !a_if.out_valid)
        bad++;
      if (a_if.out_valid && first_v < 0) first_v = t;
      if (a_if.done) begin
        n_done++;
        done_t = t;
      end
      if (t == v.exp_lat + v.stall + 1)
        rdy_after = a_if.in_ready;
    end
    chk($sformatf("v%0d_rounds", idx), n_ren, v.nr);
    chk($sformatf("v%0d_csts", idx), n_cst, v.nr);
    chk($sformatf("v%0d_valid_lat", idx),
        first_v, v.exp_lat);
    chk($sformatf("v%0d_done_t", idx),
        done_t, v.exp_lat + v.stall);
    chk($sformatf("v%0d_done_cnt", idx), n_done, 1);
    chk($sformatf("v%0d_timing", idx), bad, 0);
    chk($sformatf("v%0d_ready_after", idx), rdy_after, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ren, n_done, n_valid, n_err, first_v, bad;
    int rc_mid, rdy;

    vecs[0] = '{4'd12, 0,  0, 0,  73};
    vecs[1] = '{4'd6,  10, 0, 6,  37};
    vecs[2] = '{4'd0,  0,  1, 0,  0};
    vecs[3] = '{4'd13, 0,  1, 0,  0};
    vecs[4] = '{4'd1,  0,  0, 11, 7};
    vecs[5] = '{4'd15, 0,  1, 0,  0};
    vecs[6] = '{4'd8,  3,  0, 4,  49};

    reset = 1'b1;
    a_if.start = 1'b0; a_if.nrounds = 4'd0;
    a_if.out_ready = 1'b0;
    b_if.start = 1'b0; b_if.nrounds = 4'd0;
    b_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", a_if.in_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_rc_idx", a_rc, 12);
    chk("rst_pulses",
        {a_load, a_cst, a_ren, a_rnd,
         a_if.done, a_if.err}, 0);
    chk("rst_b_rc_idx", b_rc, 12);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // start while computing must be ignored
    n_ren = 0; n_done = 0; n_err = 0;
    first_v = -1; rc_mid = -1;
    @(posedge clk); #1;
    a_if.start = 1'b1; a_if.nrounds = 4'd2;
    a_if.out_ready = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      @(posedge clk); #1;
      a_if.start   = (t == 3);
      a_if.nrounds = (t == 3) ? 4'd5 : 4'd2;
      #1;
      if (a_if.err) n_err++;
      if (t == 3) rc_mid = a_rc;
      if (a_ren) n_ren++;
      if (a_if.done) n_done++;
      if (a_if.out_valid && first_v < 0) first_v = t;
    end
    a_if.start = 1'b0;
    chk("busy_start_err", n_err, 0);
    chk("busy_start_rc", rc_mid, 10);
    chk("busy_start_rounds", n_ren, 2);
    chk("busy_start_valid", first_v, 13);
    chk("busy_start_done", n_done, 1);

    // reset in the middle of a 12-round run
    @(posedge clk); #1;
    a_if.start = 1'b1; a_if.nrounds = 4'd12;
    a_if.out_ready = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      a_if.start = 1'b0;
      if (t == 20) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_idle",
        {a_if.in_ready, a_busy}, 2);
    n_valid = 0; n_done = 0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (a_if.out_valid) n_valid++;
      if (a_if.done) n_done++;
    end
    chk("rst_mid_no_valid", n_valid, 0);
    chk("rst_mid_no_done", n_done, 0);
    @(posedge clk); #1;
    a_if.start = 1'b1; a_if.nrounds = 4'd1;
    #1;
    chk("rst_mid_restart", a_load, 1);
    n_done = 0;
    for (int t = 1; t <= 9; t++) begin
      @(posedge clk); #1;
      a_if.start = 1'b0;
      #1;
      if (a_if.done) n_done++;
    end
    chk("rst_mid_restart_done", n_done, 1);

    // single-cycle rounds
    bad = 0; n_ren = 0; first_v = -1; n_done = 0;
    @(posedge clk); #1;
    b_if.start = 1'b1; b_if.nrounds = 4'd8;
    b_if.out_ready = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      @(posedge clk); #1;
      b_if.start = 1'b0;
      #1;
      if (t <= 8) begin
        if (!(b_cst && b_ren)) bad++;
        if (b_rc != 4 + t - 1) bad++;
      end else if (b_cst || b_ren) begin
        bad++;
      end
      if (b_ren) n_ren++;
      if (b_if.out_valid && first_v < 0) first_v = t;
      if (b_if.done) n_done++;
    end
    chk("lat1_pattern", bad, 0);
    chk("lat1_rounds", n_ren, 8);
    chk("lat1_valid", first_v, 9);
    chk("lat1_done", n_done, 1);

`ifdef ASCON_PERM_CTRL_ABORT_EN
    n_done = 0; n_valid = 0; rdy = 0; bad = 0;
    @(posedge clk); #1;
    b_if.start = 1'b1; b_if.nrounds = 4'd8;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      b_if.start = 1'b0;
      b_abort = (t == 3);
      #1;
      if (t == 3 && b_ren) bad++;
      if (t == 4) rdy = {b_if.in_ready, b_busy};
      if (b_if.out_valid) n_valid++;
      if (b_if.done) n_done++;
    end
    b_abort = 1'b0;
    chk("abort_ren_forced", bad, 0);
    chk("abort_idle", rdy, 2);
    chk("abort_no_valid", n_valid, 0);
    chk("abort_no_done", n_done, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
